// File: rtl/lfsr_random_stream.sv
// lfsr_random_stream: Fibonacci-LFSR pseudo-random sample source with a
// valid/ready output handshake, runtime reseed and step enable.
// The LFSR advances STEPS shifts between captured samples so that
// consecutive outputs are decorrelated.
// Optional build macro LFSR_RANGE_EN: the captured sample is folded into
// the range 0..RANGE_MAX instead of being the full LFSR value.
module lfsr_random_stream #(
    parameter int               WIDTH     = 20,
    parameter logic [WIDTH-1:0] TAPS      = 20'h90000,
    parameter logic [WIDTH-1:0] SEED      = 20'h00001,
    parameter int               STEPS     = 20,
    parameter int               RANGE_MAX = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_seed_load,
    input  logic [WIDTH-1:0] i_seed_in,
    input  logic             i_rnd_ready,
    output logic             o_rnd_valid,
    output logic [WIDTH-1:0] o_rnd_out
);

    // An all-zero LFSR never leaves zero, so zero seeds are replaced by 1.
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? ONE : SEED;
    localparam int               CW       = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0]    LAST     = CW'(STEPS - 1);

    typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_lfsr;
    logic [CW-1:0]    r_count;
    logic             r_valid;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_cap;
    logic [WIDTH-1:0] w_seed;
    logic             w_capture;
    logic             w_advance;
    logic             w_accept;

    // Next LFSR value; a zero register recovers to 1 instead of stepping.
    assign w_step = (r_lfsr == '0) ? ONE : {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
    assign w_seed = (i_seed_in == '0) ? ONE : i_seed_in;

`ifdef LFSR_RANGE_EN
    localparam int          RB   = $clog2(RANGE_MAX + 1);
    localparam logic [RB:0] RMAX = (RB + 1)'(RANGE_MAX);
    localparam logic [RB:0] RMOD = (RB + 1)'(RANGE_MAX + 1);
    logic [RB:0] w_v;
    logic [RB:0] w_fold;
    // Fold the low RB bits into 0..RANGE_MAX with a single conditional subtract.
    always_comb begin
        w_v    = {1'b0, w_step[RB-1:0]};
        w_fold = (w_v > RMAX) ? (w_v - RMOD) : w_v;
        w_cap  = WIDTH'(w_fold[RB-1:0]);
    end
`else
    assign w_cap = w_step;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_RUN;
        else         r_state <= w_state_nxt;
    end

    // Next-state: reseed always returns to RUN and discards any pending sample.
    always_comb begin
        w_state_nxt = r_state;
        if (i_seed_load) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:  if (i_en && (r_count == LAST)) w_state_nxt = ST_HOLD;
                ST_HOLD: if (r_valid && i_rnd_ready)    w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    // FSM outputs: datapath strobes for stepping, capturing and handing off.
    always_comb begin
        w_advance = 1'b0;
        w_capture = 1'b0;
        w_accept  = 1'b0;
        if (!i_seed_load) begin
            case (r_state)
                ST_RUN: begin
                    w_advance = i_en;
                    w_capture = i_en && (r_count == LAST);
                end
                ST_HOLD: w_accept = r_valid && i_rnd_ready;
                default: ;
            endcase
        end
    end

    // Datapath: LFSR, step counter and sample register; frozen while holding.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr  <= SEED_EFF;
            r_count <= '0;
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (i_seed_load) begin
            r_lfsr  <= w_seed;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_advance) begin
                r_lfsr  <= w_step;
                r_count <= w_capture ? '0 : r_count + 1'b1;
            end
            if (w_capture) begin
                r_out   <= w_cap;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_rnd_valid = r_valid;
    assign o_rnd_out   = r_out;

endmodule

// File: tb/tb_lfsr_random_stream.sv
// Directed testbench for lfsr_random_stream (defaults, STEPS=20, x^20+x^17+1).
// With LFSR_RANGE_EN defined the range-folding scenario runs with RANGE_MAX=8.
module tb_lfsr_random_stream;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         sl;
    logic [W-1:0] sin;
    logic         rdy;
    logic         vld;
    logic [W-1:0] out;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    lfsr_random_stream #(
        .WIDTH(W), .TAPS(20'h90000), .SEED(20'h00001), .STEPS(20), .RANGE_MAX(8)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_seed_load(sl), .i_seed_in(sin),
        .i_rnd_ready(rdy), .o_rnd_valid(vld), .o_rnd_out(out)
    );

    // Reference LFSR for x^20+x^17+1: feedback from bits 19 and 16.
    function automatic logic [W-1:0] mstep(input logic [W-1:0] v);
        return (v == '0) ? 20'h1 : {v[18:0], v[19] ^ v[16]};
    endfunction

    function automatic logic [W-1:0] msample(input logic [W-1:0] v);
        logic [W-1:0] t;
        t = v;
        for (int k = 0; k < 20; k++) t = mstep(t);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < budget && !ok) begin
            tick();
            cyc++;
            if (vld === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; en = 1'b0; sl = 1'b0; sin = '0; rdy = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; sl = 1'b0; sin = '0; rdy = 1'b0;
        tick();
        tick();
        vectors++;
        if (vld !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", vld); end
        vectors++;
        if (out !== 20'h0) begin errors++; $display("FAIL reset_out: got %h want 00000", out); end
        rst = 1'b0; en = 1'b0;
    endtask

    task automatic test_first_sample();
        int cyc; bit ok; logic [W-1:0] exp2;
        apply_reset();
        en = 1'b1; rdy = 1'b0;
        wait_valid(40, cyc, ok);
        vectors++;
        if (!ok || cyc != 20) begin errors++; $display("FAIL first_latency: got %0d (ok=%b) want 20", cyc, ok); end
        vectors++;
        if (out !== 20'h00009) begin errors++; $display("FAIL first_value: got %h want 00009", out); end
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (vld !== 1'b1 || out !== 20'h00009) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin errors++; $display("FAIL hold_stable: got vld=%b out=%h want 1/00009", vld, out); end
        // After a long hold the next sample must still be the next decimation.
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        vectors++;
        if (vld !== 1'b0) begin errors++; $display("FAIL hold_accept: got %b want 0", vld); end
        exp2 = msample(msample(20'h1));
        wait_valid(40, cyc, ok);
        vectors++;
        if (!ok || cyc != 20 || out !== exp2) begin
            errors++; $display("FAIL second_sample: got %h after %0d want %h after 20", out, cyc, exp2);
        end
    endtask

    task automatic test_stream();
        int cyc; bit ok; bit uniq;
        logic [W-1:0] m;
        logic [W-1:0] seen [1000];
        apply_reset();
        en = 1'b1; rdy = 1'b1;
        m = 20'h1;
        for (int i = 0; i < 1000; i++) begin
            wait_valid(40, cyc, ok);
            m = msample(m);
            seen[i] = out;
            vectors++;
            if (!ok || cyc != ((i == 0) ? 20 : 21)) begin
                errors++; $display("FAIL stream_interval[%0d]: got %0d want %0d", i, cyc, (i == 0) ? 20 : 21);
            end
            vectors++;
            if (out !== m) begin errors++; $display("FAIL stream_value[%0d]: got %h want %h", i, out, m); end
        end
        uniq = 1'b1;
        for (int i = 0; i < 1000; i++)
            for (int j = i + 1; j < 1000; j++)
                if (seen[i] === seen[j]) uniq = 1'b0;
        vectors++;
        if (!uniq) begin errors++; $display("FAIL stream_unique: got repeat want none"); end
        rdy = 1'b0;
    endtask

    task automatic test_reseed();
        int cyc; bit ok; logic [W-1:0] e;
        apply_reset();
        en = 1'b1; rdy = 1'b0;
        wait_valid(40, cyc, ok);
        sl = 1'b1; sin = 20'h12345; rdy = 1'b1;
        tick();
        sl = 1'b0; rdy = 1'b0;
        vectors++;
        if (vld !== 1'b0) begin errors++; $display("FAIL reseed_discard: got %b want 0", vld); end
        vectors++;
        if (out !== 20'h00009) begin errors++; $display("FAIL reseed_out_kept: got %h want 00009", out); end
        e = msample(20'h12345);
        wait_valid(40, cyc, ok);
        vectors++;
        if (!ok || cyc != 20 || out !== e) begin
            errors++; $display("FAIL reseed_value: got %h after %0d want %h after 20", out, cyc, e);
        end
        sl = 1'b1; sin = 20'h0; rdy = 1'b1;
        tick();
        sl = 1'b0; rdy = 1'b0;
        vectors++;
        if (vld !== 1'b0 || out !== e) begin
            errors++; $display("FAIL reseed0_discard: got vld=%b out=%h want 0/%h", vld, out, e);
        end
        wait_valid(40, cyc, ok);
        vectors++;
        if (!ok || cyc != 20 || out !== 20'h00009) begin
            errors++; $display("FAIL reseed0_value: got %h after %0d want 00009 after 20", out, cyc);
        end
    endtask

    task automatic test_en_toggle();
        int ecount; bit done;
        apply_reset();
        rdy = 1'b0;
        ecount = 0;
        done = 1'b0;
        for (int t = 0; t < 80 && !done; t++) begin
            en = ((t / 3) % 2) == 0;
            tick();
            if (en) ecount++;
            if (vld === 1'b1) begin
                done = 1'b1;
                vectors++;
                if (ecount != 20) begin errors++; $display("FAIL en_latency: got %0d want 20", ecount); end
                vectors++;
                if (out !== 20'h00009) begin errors++; $display("FAIL en_value: got %h want 00009", out); end
            end
        end
        vectors++;
        if (!done) begin errors++; $display("FAIL en_timeout: got no valid want valid"); end
        en = 1'b0; rdy = 1'b1;
        tick();
        rdy = 1'b0;
        vectors++;
        if (vld !== 1'b0) begin errors++; $display("FAIL accept_en0: got %b want 0", vld); end
    endtask

    task automatic test_reset_in_hold();
        int cyc; bit ok;
        apply_reset();
        en = 1'b1; rdy = 1'b0;
        wait_valid(40, cyc, ok);
        rst = 1'b1; rdy = 1'b1;
        tick();
        rst = 1'b0; rdy = 1'b0;
        vectors++;
        if (vld !== 1'b0 || out !== 20'h0) begin
            errors++; $display("FAIL hold_reset: got vld=%b out=%h want 0/00000", vld, out);
        end
        wait_valid(40, cyc, ok);
        vectors++;
        if (!ok || cyc != 20 || out !== 20'h00009) begin
            errors++; $display("FAIL hold_reset_restart: got %h after %0d want 00009 after 20", out, cyc);
        end
    endtask

    task automatic test_range();
        int cyc; bit ok; bit inr;
        logic [W-1:0] m, e;
        logic [3:0]   lo;
        logic [8:0]   hit;
        apply_reset();
        en = 1'b1; rdy = 1'b1;
        m = 20'h1; hit = '0; inr = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            wait_valid(40, cyc, ok);
            m  = msample(m);
            lo = m[3:0];
            e  = (lo > 4'd8) ? W'(lo - 4'd9) : W'(lo);
            if (i == 0) begin
                vectors++;
                if (out !== 20'h0) begin errors++; $display("FAIL range_first: got %h want 00000", out); end
            end
            vectors++;
            if (!ok || out !== e) begin errors++; $display("FAIL range_value[%0d]: got %h want %h", i, out, e); end
            if (out > 20'd8) inr = 1'b0;
            else hit[out[3:0]] = 1'b1;
        end
        vectors++;
        if (!inr) begin errors++; $display("FAIL range_bound: got value >8 want <=8"); end
        vectors++;
        if (hit !== 9'h1FF) begin errors++; $display("FAIL range_cover: got %b want 111111111", hit); end
        rdy = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef LFSR_RANGE_EN
        test_range();
`else
        test_first_sample();
        test_stream();
        test_reseed();
        test_en_toggle();
        test_reset_in_hold();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
